// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: widths, opcode constants and sequencer states.
package cpu_pkg;

  localparam int unsigned CPU_DATA_WIDTH    = 8;
  localparam int unsigned CPU_ADDRESS_WIDTH = 8;
  localparam int unsigned REG_ADDR_WIDTH    = 2;
  localparam int unsigned OPCODE_WIDTH      = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = 4'h4;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = 4'h5;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = 4'h6;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 4'h7;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 4'h8;
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ   = 4'h9;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_START,
    ST_FETCH,
    ST_DECODE,
    ST_READ_A,
    ST_READ_B,
    ST_FETCH_IMM,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  // Two-operand ALU instructions that read rd before rs.
  function automatic logic is_alu_op(input logic [OPCODE_WIDTH-1:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; MOV and LDI pass operand b through unchanged.
module alu
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CPU_DATA_WIDTH
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [DATA_WIDTH-1:0]   result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_MOV:  result = b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LDI:  result = b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle fetch/decode/execute sequencer driving a single-read-port register file.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = CPU_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = CPU_ADDRESS_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      instr_request,
  output logic [ADDRESS_WIDTH-1:0]  instr_address,
  input  logic                      instr_ready,
  input  logic [DATA_WIDTH-1:0]     instr_data,
  output logic [REG_ADDR_WIDTH-1:0] rf_read_address,
  input  logic [DATA_WIDTH-1:0]     rf_read_data,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_address,
  output logic [DATA_WIDTH-1:0]     rf_write_data,
  output logic                      rf_write_enable,
  output logic                      zero_flag,
  output logic                      halted
);

  state_t                    state, state_n;
  logic [ADDRESS_WIDTH-1:0]  pc, pc_n, pc_inc;
  logic [DATA_WIDTH-1:0]     ir, ir_n, a, a_n, b, b_n, imm, imm_n;
  logic [OPCODE_WIDTH-1:0]   op, op_n;
  logic [DATA_WIDTH-1:0]     alu_b, result;

  logic                      request_n, we_n, z_n, halted_n;
  logic [ADDRESS_WIDTH-1:0]  address_n;
  logic [REG_ADDR_WIDTH-1:0] raddr_n, waddr_n;
  logic [DATA_WIDTH-1:0]     wdata_n;

  assign op = ir[7:4];

  // Next-state and next-register logic.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    a_n     = a;
    b_n     = b;
    imm_n   = imm;
    pc_inc  = pc + ADDRESS_WIDTH'(1);
    case (state)
      ST_START: state_n = ST_FETCH;
      ST_FETCH: begin
        if (instr_ready) begin
          ir_n    = instr_data;
          pc_n    = pc_inc;
          state_n = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_alu_op(op))                                  state_n = ST_READ_A;
        else if (op == OP_MOV)                              state_n = ST_READ_B;
        else if (op == OP_LDI || op == OP_JMP || op == OP_JZ) state_n = ST_FETCH_IMM;
        else if (op == OP_HALT)                             state_n = ST_HALT;
        else                                                state_n = ST_FETCH;
      end
      ST_READ_A: begin
        a_n     = rf_read_data;
        state_n = ST_READ_B;
      end
      ST_READ_B: begin
        b_n     = rf_read_data;
        state_n = ST_WRITEBACK;
      end
      ST_FETCH_IMM: begin
        if (instr_ready) begin
          imm_n   = instr_data;
          pc_n    = pc_inc;
          state_n = ST_FETCH;
          if (op == OP_LDI) state_n = ST_WRITEBACK;
          else if (op == OP_JMP || (op == OP_JZ && zero_flag))
            pc_n = ADDRESS_WIDTH'(instr_data);
        end
      end
      ST_WRITEBACK: state_n = ST_FETCH;
      ST_HALT:      state_n = ST_HALT;
      default:      state_n = ST_START;
    endcase
  end

  assign op_n  = ir_n[7:4];
  assign alu_b = (op_n == OP_LDI) ? imm_n : b_n;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .opcode (op_n),
    .a      (a_n),
    .b      (alu_b),
    .result (result)
  );

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    request_n = (state_n == ST_FETCH) || (state_n == ST_FETCH_IMM);
    address_n = pc_n;
    raddr_n   = '0;
    if (state_n == ST_READ_A)      raddr_n = ir_n[3:2];
    else if (state_n == ST_READ_B) raddr_n = ir_n[1:0];
    we_n      = (state_n == ST_WRITEBACK);
    waddr_n   = we_n ? ir_n[3:2] : '0;
    wdata_n   = we_n ? result : '0;
    z_n       = we_n ? (result == '0) : zero_flag;
    halted_n  = (state_n == ST_HALT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= ST_START;
      pc               <= '0;
      ir               <= '0;
      a                <= '0;
      b                <= '0;
      imm              <= '0;
      instr_request    <= 1'b0;
      instr_address    <= '0;
      rf_read_address  <= '0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
      rf_write_enable  <= 1'b0;
      zero_flag        <= 1'b0;
      halted           <= 1'b0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      ir               <= ir_n;
      a                <= a_n;
      b                <= b_n;
      imm              <= imm_n;
      instr_request    <= request_n;
      instr_address    <= address_n;
      rf_read_address  <= raddr_n;
      rf_write_address <= waddr_n;
      rf_write_data    <= wdata_n;
      rf_write_enable  <= we_n;
      zero_flag        <= z_n;
      halted           <= halted_n;
    end
  end

endmodule
